seg7_scan_display: RTL and testbench
====================================

Name: seg7_scan_display

Overview:
- Drives an 8-digit multiplexed common-anode 7-segment display from the BCD time/week digits produced by the timekeeper.
- Sits directly downstream of the timekeeper, with the digits wired straight in.
- Scans one digit at a time with anti-ghost blanking.
- Snapshots the inputs once per frame so a frame never mixes old and new values.
- Blinks the digit group currently being adjusted.

Parameters:
- SCAN_DIV, 50000: CLK cycles per digit slot (1 kHz digit rate at 50 MHz).
- BLANK_CYC, 16: cycles all digits are held off after each digit switch. Must be >=1 and < SCAN_DIV.
- BLINK_FRAMES, 31: full frames per blink half-period (about 2 Hz).

Ports:
- CLK, in, 1: system clock.
- RSTn, in, 1: asynchronous active-low reset.
- SecL/SecH/MinL/MinH/HourL/HourH, in, 4 each: BCD digits from the timekeeper.
- Week, in, 4: 1..7.
- AdjtWeek/AdjtHour/AdjtMin, in, 1 each: adjust-mode levels, used for blink selection only.
- Seg, out, 8: {dp,g,f,e,d,c,b,a}, active-low.
- Dig, out, 8: digit enables, active-low; bit i = display position i.

Behaviour:
- Interface: reset RSTn, asynchronous, active-low; clock CLK. All inputs are registered in CLK-derived logic; no synchronisers are required.
- Reset values (applied immediately on assertion, including mid-scan):
  - Seg=8'hFF, Dig=8'hFF.
  - PreCnt=0, Index=0, BlankCnt=BLANK_CYC, FrameCnt=0, BlinkPhase=0.
  - Snapshot: all digits 0, Week 1.
- Prescaler: PreCnt counts 0..SCAN_DIV-1. Tick = (PreCnt==SCAN_DIV-1). On a tick:
  - PreCnt<=0.
  - Index<=Index+1, wrapping 7->0.
  - BlankCnt<=BLANK_CYC.
  - Dig<=8'hFF.
- Blanking:
  - While BlankCnt!=0 and no tick: BlankCnt decrements and Dig stays 8'hFF.
  - When BlankCnt==0: Dig = ~(1<<Index).
  - Result: each digit is lit for SCAN_DIV-BLANK_CYC cycles per slot.
- Snapshot: on a tick with Index==7 (the wrap to 0), all seven input digits are latched. Display data comes only from the snapshot.
- Position map:
  - 7: Week.
  - 6: always blank.
  - 5: HourH. 4: HourL. 3: MinH. 2: MinL. 1: SecH. 0: SecL.
- Glyph encoding:
  - BCD 0..9 decodes to the standard glyph; 0=0x3F ... 9=0x6F, active-high form before inversion.
  - Any digit >9 shows a dash (0x40).
  - Week outside 1..7 shows a dash.
- Separators: the dp on positions 4 and 2 is lit iff snapshot SecL[0]==0, giving a 1 Hz blink. The dp is off on all other positions.
- Blink:
  - FrameCnt increments at each wrap. At BLINK_FRAMES-1 it clears and BlinkPhase toggles.
  - When BlinkPhase==1, the glyph bits (not dp) are blanked for the adjusted group:
    - AdjtWeek -> pos 7.
    - AdjtHour -> pos 5,4.
    - AdjtMin -> pos 3,2.
  - Masks are independent; several can be active together.
  - Dig scanning is unaffected, so brightness stays uniform.
- Seg register: loaded every cycle from glyph(Index, snapshot, blink), so it lags Index by 1 cycle. Because BLANK_CYC>=1, Seg is stable before its Dig bit asserts.
- Adjust inputs changing mid-frame take effect from the next cycle. The blink mask is not snapshotted.

Decomposition:
- Package seg7_pkg:
  - Glyph constants SEG_0..SEG_9, SEG_DASH=8'h40, SEG_OFF=8'h00.
  - Position constants POS_WEEK=7, POS_HOURH=5, ..., POS_SECL=0.
  - DP bit index 7.
- Sub-module bcd_to_seg7: combinational 4-bit -> 7-bit active-high decoder with dash for >9.
- The top level handles the active-low inversion and the dp.

Test Plan:
Bench parameters: SCAN_DIV=4, BLANK_CYC=1, BLINK_FRAMES=2.
1. Reset: hold RSTn=0 -> Seg=8'hFF, Dig=8'hFF. Release -> Dig=8'hFE from cycle 1, first tick at cycle 3, Dig=8'hFF for 1 cycle, then 8'hFD.
2. Inputs Week=3, time 23:59:58, one frame elapsed:
   - pos5 -> Seg=8'hA4, Dig=8'hDF.
   - pos4 -> Seg=8'h30 ('3' with dp).
   - pos6 -> Seg=8'hFF.
   - pos7 -> Seg=8'hB0.
3. Tearing: change SecL 8->9 while Index=3 -> pos0 still shows '8' (8'h80) this frame and '9' (8'h90) next frame. The dp on pos4/2 goes off the following frame.
4. AdjtMin=1 held: frames 0-1 pos3/pos2 normal; frames 2-3 pos3 Seg=8'hFF and pos2 dp-only per SecL[0]. Pos5/4 unchanged throughout.
5. Invalid data: MinL=4'hC -> pos2 Seg=8'hBF or 8'h3F per dp. Week=0 -> pos7 Seg=8'hBF.
6. Async reset pulse while Index=5, mid-slot -> same edge Dig=8'hFF, Seg=8'hFF. After release, scan restarts at pos0 and the snapshot reads Week 1, all others '0'.

Source files
------------

// File: rtl/seg7_pkg.sv
// ---------------------------------------------------------------------------
// seg7_pkg
// Shared constants and types for the multiplexed 7-segment scan display.
//   - SEG_0..SEG_9, SEG_DASH, SEG_OFF : active-high glyphs, bit order
//                                       {dp,g,f,e,d,c,b,a}; dp is always 0 here
//   - POS_*                          : display position of each digit
//   - DP_BIT                         : bit index of the decimal point
//   - snapshot_t                     : one frame's worth of latched digits
//   - digit_enable()                 : active-low one-hot digit enable
// ---------------------------------------------------------------------------
package seg7_pkg;

  localparam logic [7:0] SEG_0    = 8'h3F;
  localparam logic [7:0] SEG_1    = 8'h06;
  localparam logic [7:0] SEG_2    = 8'h5B;
  localparam logic [7:0] SEG_3    = 8'h4F;
  localparam logic [7:0] SEG_4    = 8'h66;
  localparam logic [7:0] SEG_5    = 8'h6D;
  localparam logic [7:0] SEG_6    = 8'h7D;
  localparam logic [7:0] SEG_7    = 8'h07;
  localparam logic [7:0] SEG_8    = 8'h7F;
  localparam logic [7:0] SEG_9    = 8'h6F;
  localparam logic [7:0] SEG_DASH = 8'h40;
  localparam logic [7:0] SEG_OFF  = 8'h00;

  localparam logic [2:0] POS_WEEK  = 3'd7;
  localparam logic [2:0] POS_BLANK = 3'd6;
  localparam logic [2:0] POS_HOURH = 3'd5;
  localparam logic [2:0] POS_HOURL = 3'd4;
  localparam logic [2:0] POS_MINH  = 3'd3;
  localparam logic [2:0] POS_MINL  = 3'd2;
  localparam logic [2:0] POS_SECH  = 3'd1;
  localparam logic [2:0] POS_SECL  = 3'd0;

  localparam int DP_BIT = 7;

  // Digits as latched at a frame boundary; the display never reads the
  // live timekeeper digits directly.
  typedef struct packed {
    logic [3:0] week;
    logic [3:0] hour_h;
    logic [3:0] hour_l;
    logic [3:0] min_h;
    logic [3:0] min_l;
    logic [3:0] sec_h;
    logic [3:0] sec_l;
  } snapshot_t;

  // Active-low enable for a single display position.
  function automatic logic [7:0] digit_enable(input logic [2:0] idx);
    return ~(8'h01 << idx);
  endfunction

endpackage

// File: rtl/seg7_scan_display_if.sv
// ---------------------------------------------------------------------------
// seg7_scan_display_if
// Bundles the timekeeper digits, the adjust-mode levels and the display
// drive lines.
//   master : timekeeper side  - drives digits/adjust, observes Seg/Dig
//   slave  : display side     - reads digits/adjust, drives Seg/Dig
// Signals:
//   SecL..HourH [3:0] BCD time digits, Week [3:0] 1..7
//   AdjtWeek/AdjtHour/AdjtMin  adjust-mode levels (blink selection)
//   Seg [7:0] {dp,g,f,e,d,c,b,a} active-low, Dig [7:0] active-low enables
// ---------------------------------------------------------------------------
interface seg7_scan_display_if;

  logic [3:0] SecL;
  logic [3:0] SecH;
  logic [3:0] MinL;
  logic [3:0] MinH;
  logic [3:0] HourL;
  logic [3:0] HourH;
  logic [3:0] Week;
  logic       AdjtWeek;
  logic       AdjtHour;
  logic       AdjtMin;
  logic [7:0] Seg;
  logic [7:0] Dig;

  modport master (
    output SecL, SecH, MinL, MinH, HourL, HourH, Week,
    output AdjtWeek, AdjtHour, AdjtMin,
    input  Seg, Dig
  );

  modport slave (
    input  SecL, SecH, MinL, MinH, HourL, HourH, Week,
    input  AdjtWeek, AdjtHour, AdjtMin,
    output Seg, Dig
  );

endinterface

// File: rtl/seg7_scan_display_bcd_to_seg7.sv
// ---------------------------------------------------------------------------
// bcd_to_seg7
// Combinational BCD to 7-segment decoder, active-high {g,f,e,d,c,b,a}.
//   bcd [3:0] : digit value
//   seg [6:0] : glyph; values above 9 show a dash
// ---------------------------------------------------------------------------
module bcd_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH[6:0];
    case (bcd)
      4'd0: seg = SEG_0[6:0];
      4'd1: seg = SEG_1[6:0];
      4'd2: seg = SEG_2[6:0];
      4'd3: seg = SEG_3[6:0];
      4'd4: seg = SEG_4[6:0];
      4'd5: seg = SEG_5[6:0];
      4'd6: seg = SEG_6[6:0];
      4'd7: seg = SEG_7[6:0];
      4'd8: seg = SEG_8[6:0];
      4'd9: seg = SEG_9[6:0];
      default: seg = SEG_DASH[6:0];
    endcase
  end

endmodule

// File: rtl/seg7_scan_display.sv
// ---------------------------------------------------------------------------
// seg7_scan_display
// 8-digit multiplexed common-anode 7-segment driver for the timekeeper.
// One digit is lit at a time; every digit switch is preceded by a short
// all-off window to avoid ghosting. The inputs are latched once per frame
// so a frame never mixes old and new values, and the digit group being
// adjusted blinks at roughly 2 Hz.
// Parameters:
//   SCAN_DIV     CLK cycles per digit slot
//   BLANK_CYC    all-off cycles after each digit switch (1 .. SCAN_DIV-1)
//   BLINK_FRAMES full frames per blink half-period
// Ports:
//   CLK   system clock
//   RSTn  asynchronous active-low reset
//   bus   slave side of seg7_scan_display_if (digits in, Seg/Dig out)
// ---------------------------------------------------------------------------
module seg7_scan_display
  import seg7_pkg::*;
#(
  parameter int SCAN_DIV     = 50000,
  parameter int BLANK_CYC    = 16,
  parameter int BLINK_FRAMES = 31
) (
  input  logic                CLK,
  input  logic                RSTn,
  seg7_scan_display_if.slave  bus
);

  localparam int PRE_W   = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int BLANK_W = $clog2(BLANK_CYC + 1);
  localparam int FRAME_W = (BLINK_FRAMES > 2) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [PRE_W-1:0]   PRE_MAX    = PRE_W'(SCAN_DIV - 1);
  localparam logic [BLANK_W-1:0] BLANK_INIT = BLANK_W'(BLANK_CYC);
  localparam logic [BLANK_W-1:0] BLANK_ONE  = BLANK_W'(1);
  localparam logic [FRAME_W-1:0] FRAME_MAX  = FRAME_W'(BLINK_FRAMES - 1);

  logic [PRE_W-1:0]   pre_cnt;
  logic [2:0]         index;
  logic [BLANK_W-1:0] blank_cnt;
  logic [FRAME_W-1:0] frame_cnt;
  logic               blink_phase;
  snapshot_t          snap;
  logic [7:0]         seg_q;
  logic [7:0]         dig_q;

  logic               tick;
  logic               wrap;

  logic [3:0]         digit_sel;
  logic               week_sel;
  logic               blank_pos;
  logic               dp_on;
  logic               blink_mask;
  logic [3:0]         dec_in;
  logic [6:0]         dec_out;
  logic [7:0]         glyph;
  logic [7:0]         seg_next;

  assign tick = (pre_cnt == PRE_MAX);
  assign wrap = tick && (index == POS_WEEK);

  // Slot timing. Dig is registered and looks one cycle ahead at the blank
  // counter, so the digit lights on the same edge the counter reaches zero;
  // with BLANK_CYC=1 that means it is lit from the first cycle after a
  // switch-off cycle, giving SCAN_DIV-BLANK_CYC lit cycles per slot.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      pre_cnt   <= '0;
      index     <= 3'd0;
      blank_cnt <= BLANK_INIT;
      dig_q     <= 8'hFF;
    end else if (tick) begin
      pre_cnt   <= '0;
      index     <= index + 3'd1;
      blank_cnt <= BLANK_INIT;
      dig_q     <= 8'hFF;
    end else begin
      pre_cnt <= pre_cnt + 1'b1;
      if (blank_cnt > BLANK_ONE) begin
        blank_cnt <= blank_cnt - 1'b1;
        dig_q     <= 8'hFF;
      end else begin
        blank_cnt <= '0;
        dig_q     <= digit_enable(index);
      end
    end
  end

  // Latch all digits as the scan wraps from position 7 back to 0, so each
  // frame is drawn from one consistent set of values.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      snap        <= '0;
      snap.week   <= 4'd1;
    end else if (wrap) begin
      snap.week   <= bus.Week;
      snap.hour_h <= bus.HourH;
      snap.hour_l <= bus.HourL;
      snap.min_h  <= bus.MinH;
      snap.min_l  <= bus.MinL;
      snap.sec_h  <= bus.SecH;
      snap.sec_l  <= bus.SecL;
    end
  end

  // Blink timebase counted in whole frames, so a blink edge never lands
  // in the middle of a frame.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (wrap) begin
      if (frame_cnt == FRAME_MAX) begin
        frame_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end

  // Select what the current position shows. The adjust levels are used
  // live rather than from the snapshot so entering adjust mode reacts at
  // once; the colon dots on positions 4 and 2 follow the seconds parity.
  always_comb begin
    digit_sel  = 4'd0;
    week_sel   = 1'b0;
    blank_pos  = 1'b0;
    dp_on      = 1'b0;
    blink_mask = 1'b0;
    case (index)
      POS_WEEK: begin
        digit_sel  = snap.week;
        week_sel   = 1'b1;
        blink_mask = bus.AdjtWeek;
      end
      POS_BLANK: begin
        blank_pos = 1'b1;
      end
      POS_HOURH: begin
        digit_sel  = snap.hour_h;
        blink_mask = bus.AdjtHour;
      end
      POS_HOURL: begin
        digit_sel  = snap.hour_l;
        blink_mask = bus.AdjtHour;
        dp_on      = ~snap.sec_l[0];
      end
      POS_MINH: begin
        digit_sel  = snap.min_h;
        blink_mask = bus.AdjtMin;
      end
      POS_MINL: begin
        digit_sel  = snap.min_l;
        blink_mask = bus.AdjtMin;
        dp_on      = ~snap.sec_l[0];
      end
      POS_SECH: begin
        digit_sel = snap.sec_h;
      end
      POS_SECL: begin
        digit_sel = snap.sec_l;
      end
      default: begin
        blank_pos = 1'b1;
      end
    endcase
  end

  // Week values 0, 8 and 9 are valid BCD but not valid weekdays; steer
  // them to a code the decoder renders as a dash.
  always_comb begin
    dec_in = digit_sel;
    if (week_sel && ((digit_sel == 4'd0) || (digit_sel > 4'd7))) begin
      dec_in = 4'hF;
    end
  end

  bcd_to_seg7 u_dec (
    .bcd (dec_in),
    .seg (dec_out)
  );

  // Blinking removes only the glyph; the dp stays so the colon keeps
  // ticking while minutes or hours are being adjusted.
  always_comb begin
    glyph = {1'b0, dec_out};
    if (blank_pos || (blink_phase && blink_mask)) begin
      glyph = SEG_OFF;
    end
    glyph[DP_BIT] = dp_on;
    seg_next = ~glyph;
  end

  // Segment register trails the index by one cycle; the blanking window
  // guarantees it has settled before the matching Dig bit turns on.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      seg_q <= 8'hFF;
    end else begin
      seg_q <= seg_next;
    end
  end

  assign bus.Seg = seg_q;
  assign bus.Dig = dig_q;

endmodule

// File: tb/tb_seg7_scan_display.sv
// ---------------------------------------------------------------------------
// tb_seg7_scan_display
// Self-checking bench for seg7_scan_display with a short scan
// (SCAN_DIV=4, BLANK_CYC=1, BLINK_FRAMES=2). Expected glyphs are queued
// when the inputs are set and compared when the DUT lights that position.
// ---------------------------------------------------------------------------
module tb_seg7_scan_display;

  localparam int SCAN_DIV     = 4;
  localparam int BLANK_CYC    = 1;
  localparam int BLINK_FRAMES = 2;

  logic CLK  = 1'b0;
  logic RSTn = 1'b0;

  seg7_scan_display_if bus ();

  seg7_scan_display #(
    .SCAN_DIV     (SCAN_DIV),
    .BLANK_CYC    (BLANK_CYC),
    .BLINK_FRAMES (BLINK_FRAMES)
  ) dut (
    .CLK  (CLK),
    .RSTn (RSTn),
    .bus  (bus)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    string      name;
    int         pos;
    logic [7:0] seg;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  // Reference active-high glyph for a decimal digit; anything else is a dash.
  function automatic logic [7:0] ref_glyph(input int v);
    case (v)
      0: return 8'h3F;
      1: return 8'h06;
      2: return 8'h5B;
      3: return 8'h4F;
      4: return 8'h66;
      5: return 8'h6D;
      6: return 8'h7D;
      7: return 8'h07;
      8: return 8'h7F;
      9: return 8'h6F;
      default: return 8'h40;
    endcase
  endfunction

  // Drive-level Seg value for a glyph plus optional dp.
  function automatic logic [7:0] drive(input logic [7:0] glyph, input bit dp);
    return ~(glyph | (dp ? 8'h80 : 8'h00));
  endfunction

  task automatic push_exp(input string name, input int pos, input logic [7:0] seg);
    exp_t e;
    e.name = name;
    e.pos  = pos;
    e.seg  = seg;
    sb.push_back(e);
  endtask

  task automatic set_inputs(input logic [3:0] wk, input logic [3:0] hh, input logic [3:0] hl,
                            input logic [3:0] mh, input logic [3:0] ml,
                            input logic [3:0] sh, input logic [3:0] sl);
    bus.Week  = wk;
    bus.HourH = hh;
    bus.HourL = hl;
    bus.MinH  = mh;
    bus.MinL  = ml;
    bus.SecH  = sh;
    bus.SecL  = sl;
  endtask

  // Advance negedge by negedge until position pos is lit (bounded).
  task automatic wait_pos(input int pos, output bit ok);
    logic [7:0] one;
    logic [7:0] want;
    one  = 8'h01;
    want = ~(one << pos);
    ok   = 1'b0;
    for (int i = 0; i < 80; i++) begin
      if (bus.Dig === want) begin
        ok = 1'b1;
        break;
      end
      @(negedge CLK);
    end
  endtask

  // Land on position 0 of a frame whose snapshot was taken after this call.
  task automatic wait_frame_start(output bit ok);
    bit ok7;
    bit ok0;
    wait_pos(7, ok7);
    wait_pos(0, ok0);
    ok = ok7 && ok0;
  endtask

  task automatic test_reset();
    logic [7:0] dig_exp[$];
    logic [7:0] d;
    bus.AdjtWeek = 1'b0;
    bus.AdjtHour = 1'b0;
    bus.AdjtMin  = 1'b0;
    set_inputs(4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0);
    RSTn = 1'b0;
    repeat (3) @(negedge CLK);
    checks++;
    if (bus.Seg !== 8'hFF) begin
      failures++;
      $display("[TB] FAIL reset_seg: Seg=%h expected ff", bus.Seg);
    end
    checks++;
    if (bus.Dig !== 8'hFF) begin
      failures++;
      $display("[TB] FAIL reset_dig: Dig=%h expected ff", bus.Dig);
    end
    dig_exp.push_back(8'hFE);
    dig_exp.push_back(8'hFE);
    dig_exp.push_back(8'hFE);
    dig_exp.push_back(8'hFF);
    dig_exp.push_back(8'hFD);
    RSTn = 1'b1;
    @(negedge CLK);
    checks++;
    if (bus.Seg !== drive(ref_glyph(0), 1'b0)) begin
      failures++;
      $display("[TB] FAIL reset_first_seg: Seg=%h expected %h", bus.Seg, drive(ref_glyph(0), 1'b0));
    end
    for (int c = 1; dig_exp.size() > 0; c++) begin
      d = dig_exp.pop_front();
      checks++;
      if (bus.Dig !== d) begin
        failures++;
        $display("[TB] FAIL reset_dig_cycle%0d: Dig=%h expected %h", c, bus.Dig, d);
      end
      @(negedge CLK);
    end
  endtask

  task automatic test_display_map();
    exp_t e;
    bit   ok;
    set_inputs(4'd3, 4'd2, 4'd3, 4'd5, 4'd9, 4'd5, 4'd8);
    wait_frame_start(ok);
    push_exp("map_pos0", 0, 8'h80);
    push_exp("map_pos1", 1, drive(ref_glyph(5), 1'b0));
    push_exp("map_pos2", 2, drive(ref_glyph(9), 1'b1));
    push_exp("map_pos3", 3, drive(ref_glyph(5), 1'b0));
    push_exp("map_pos4", 4, 8'h30);
    push_exp("map_pos5", 5, 8'hA4);
    push_exp("map_pos6", 6, 8'hFF);
    push_exp("map_pos7", 7, 8'hB0);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      wait_pos(e.pos, ok);
      checks++;
      if (!ok) begin
        failures++;
        $display("[TB] FAIL %s_timeout: Dig=%h never selected pos %0d", e.name, bus.Dig, e.pos);
      end else begin
        checks++;
        if (bus.Seg !== e.seg) begin
          failures++;
          $display("[TB] FAIL %s: Seg=%h expected %h", e.name, bus.Seg, e.seg);
        end
      end
    end
  endtask

  task automatic test_tearing();
    exp_t e;
    bit   ok;
    wait_frame_start(ok);
    push_exp("tear_pos0_old", 0, 8'h80);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      wait_pos(e.pos, ok);
      checks++;
      if (!ok) begin
        failures++;
        $display("[TB] FAIL %s_timeout: Dig=%h never selected pos %0d", e.name, bus.Dig, e.pos);
      end else begin
        checks++;
        if (bus.Seg !== e.seg) begin
          failures++;
          $display("[TB] FAIL %s: Seg=%h expected %h", e.name, bus.Seg, e.seg);
        end
      end
    end
    wait_pos(3, ok);
    bus.SecL = 4'd9;
    push_exp("tear_pos4_same_frame", 4, 8'h30);
    push_exp("tear_pos0_new", 0, 8'h90);
    push_exp("tear_pos2_dp_off", 2, drive(ref_glyph(9), 1'b0));
    push_exp("tear_pos4_dp_off", 4, drive(ref_glyph(3), 1'b0));
    while (sb.size() > 0) begin
      e = sb.pop_front();
      wait_pos(e.pos, ok);
      checks++;
      if (!ok) begin
        failures++;
        $display("[TB] FAIL %s_timeout: Dig=%h never selected pos %0d", e.name, bus.Dig, e.pos);
      end else begin
        checks++;
        if (bus.Seg !== e.seg) begin
          failures++;
          $display("[TB] FAIL %s: Seg=%h expected %h", e.name, bus.Seg, e.seg);
        end
      end
    end
  endtask

  task automatic test_blink();
    exp_t e;
    bit   ok;
    bit   phase;
    bit   f0;
    set_inputs(4'd3, 4'd2, 4'd3, 4'd5, 4'd9, 4'd5, 4'd8);
    bus.AdjtMin  = 1'b1;
    bus.AdjtWeek = 1'b1;
    RSTn = 1'b0;
    @(negedge CLK);
    RSTn = 1'b1;
    // Frame 0 still shows the reset snapshot; blink phase is on in frames 2-3.
    for (int f = 0; f < 5; f++) begin
      phase = (f == 2) || (f == 3);
      f0    = (f == 0);
      push_exp($sformatf("blink_f%0d_pos2", f), 2,
               drive(phase ? 8'h00 : ref_glyph(f0 ? 0 : 9), 1'b1));
      push_exp($sformatf("blink_f%0d_pos3", f), 3,
               drive(phase ? 8'h00 : ref_glyph(f0 ? 0 : 5), 1'b0));
      push_exp($sformatf("blink_f%0d_pos4", f), 4, drive(ref_glyph(f0 ? 0 : 3), 1'b1));
      push_exp($sformatf("blink_f%0d_pos5", f), 5, drive(ref_glyph(f0 ? 0 : 2), 1'b0));
      push_exp($sformatf("blink_f%0d_pos7", f), 7,
               drive(phase ? 8'h00 : ref_glyph(f0 ? 1 : 3), 1'b0));
    end
    while (sb.size() > 0) begin
      e = sb.pop_front();
      wait_pos(e.pos, ok);
      checks++;
      if (!ok) begin
        failures++;
        $display("[TB] FAIL %s_timeout: Dig=%h never selected pos %0d", e.name, bus.Dig, e.pos);
      end else begin
        checks++;
        if (bus.Seg !== e.seg) begin
          failures++;
          $display("[TB] FAIL %s: Seg=%h expected %h", e.name, bus.Seg, e.seg);
        end
      end
    end
    bus.AdjtMin  = 1'b0;
    bus.AdjtWeek = 1'b0;
  endtask

  task automatic test_invalid();
    exp_t e;
    bit   ok;
    set_inputs(4'd0, 4'hF, 4'd3, 4'd5, 4'hC, 4'd5, 4'd8);
    wait_frame_start(ok);
    push_exp("inv_minl_dash_dp", 2, 8'h3F);
    push_exp("inv_hourh_dash", 5, 8'hBF);
    push_exp("inv_week0_dash", 7, 8'hBF);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      wait_pos(e.pos, ok);
      checks++;
      if (!ok) begin
        failures++;
        $display("[TB] FAIL %s_timeout: Dig=%h never selected pos %0d", e.name, bus.Dig, e.pos);
      end else begin
        checks++;
        if (bus.Seg !== e.seg) begin
          failures++;
          $display("[TB] FAIL %s: Seg=%h expected %h", e.name, bus.Seg, e.seg);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    exp_t e;
    bit   ok;
    wait_pos(5, ok);
    #2;
    RSTn = 1'b0;
    #1;
    checks++;
    if (bus.Dig !== 8'hFF) begin
      failures++;
      $display("[TB] FAIL async_dig: Dig=%h expected ff", bus.Dig);
    end
    checks++;
    if (bus.Seg !== 8'hFF) begin
      failures++;
      $display("[TB] FAIL async_seg: Seg=%h expected ff", bus.Seg);
    end
    @(negedge CLK);
    RSTn = 1'b1;
    @(negedge CLK);
    checks++;
    if (bus.Dig !== 8'hFE) begin
      failures++;
      $display("[TB] FAIL async_restart_dig: Dig=%h expected fe", bus.Dig);
    end
    push_exp("async_pos0", 0, drive(ref_glyph(0), 1'b0));
    push_exp("async_pos2", 2, drive(ref_glyph(0), 1'b1));
    push_exp("async_pos4", 4, drive(ref_glyph(0), 1'b1));
    push_exp("async_pos5", 5, drive(ref_glyph(0), 1'b0));
    push_exp("async_pos7_week1", 7, drive(ref_glyph(1), 1'b0));
    while (sb.size() > 0) begin
      e = sb.pop_front();
      wait_pos(e.pos, ok);
      checks++;
      if (!ok) begin
        failures++;
        $display("[TB] FAIL %s_timeout: Dig=%h never selected pos %0d", e.name, bus.Dig, e.pos);
      end else begin
        checks++;
        if (bus.Seg !== e.seg) begin
          failures++;
          $display("[TB] FAIL %s: Seg=%h expected %h", e.name, bus.Seg, e.seg);
        end
      end
    end
  endtask

  initial begin
    $display("[TB] seg7_scan_display bench start");
    test_reset();
    test_display_map();
    test_tearing();
    test_blink();
    test_invalid();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
